// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched: schedules tagged FP add/sub requests onto one adder and queues results.
// Ports: clk/rst (sync, active-high); req_* valid/ready request in (sub flips B sign);
// op1/op2/add_start/add_serv to adder, add_result/add_done/add_busy from adder;
// rsp_* valid/ready response out of a DEPTH-entry FIFO; busy = FSM not idle.
// Option: define FP_SCHED_SPECIAL_BYPASS_EN to resolve Inf/NaN/zero-exponent operands
// without the adder (rsp_err flags Inf/NaN); otherwise rsp_err is always 0.
module fp_addsub_sched #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sub,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      op1,
  output logic [31:0]      op2,
  output logic             add_start,
  output logic             add_serv,
  input  logic [31:0]      add_result,
  input  logic             add_done,
  input  logic             add_busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 33 + TAG_W;
  typedef enum logic [2:0] {IDLE, START, WAIT, SERV, BYP} state_t;
  state_t state, state_nx;
  logic [TAG_W-1:0] tag;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] din, head;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [31:0] b_eff, byp_res, byp_q;
  logic byp_err, byp_hit, err_q, acc, push, pop;
  assign b_eff = {req_b[31] ^ req_sub, req_b[30:0]};
`ifdef FP_SCHED_SPECIAL_BYPASS_EN
  always_comb begin
    byp_err = &req_a[30:23] || &b_eff[30:23];
    byp_hit = byp_err || ~|req_a[30:23] || ~|b_eff[30:23];
    byp_res = byp_err ? 32'h7FC0_0000 : ~|req_a[30:23] ? b_eff : req_a;
  end
`else
  assign byp_err = 1'b0;
  assign byp_hit = 1'b0;
  assign byp_res = '0;
`endif
  assign req_ready = !rst && state == IDLE && cnt < (AW+1)'(DEPTH);
  assign acc = req_valid && req_ready;
  // Start is held off while the adder still reports busy/done; the FSM waits in START.
  assign add_start = state == START && !add_done && !add_busy;
  assign add_serv = state == SERV;
  assign busy = state != IDLE;
  assign push = (state == WAIT && add_done) || state == BYP;
  assign din = state == BYP ? {err_q, tag, byp_q} : {1'b0, tag, add_result};
  assign rsp_valid = cnt != '0;
  assign pop = rsp_valid && rsp_ready;
  assign head = rsp_valid ? mem[rp] : '0;
  assign {rsp_err, rsp_tag, rsp_result} = head;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc) state_nx = byp_hit ? BYP : START;
      START:   if (add_start) state_nx = WAIT;
      WAIT:    if (add_done) state_nx = SERV;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op1 <= '0;
      op2 <= '0;
      tag <= '0;
      byp_q <= '0;
      err_q <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        op1 <= req_a;
        op2 <= b_eff;
        tag <= req_tag;
        byp_q <= byp_res;
        err_q <= byp_err;
      end
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: tb/tb_fp_addsub_sched.sv
// tb_fp_addsub_sched: directed self-checking bench with a behavioural adder stand-in.
module tb_fp_addsub_sched;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_sub = 0, rsp_ready = 0;
  logic [31:0] req_a = 0, req_b = 0;
  logic [3:0] req_tag = 0;
  logic req_ready, add_start, add_serv, add_done, add_busy, rsp_valid, rsp_err, busy;
  logic [31:0] op1, op2, add_result, rsp_result;
  logic [3:0] rsp_tag;
  int cmp = 0, errs = 0, m_cnt = 0;
  logic m_busy = 0, m_done = 0;

  always #5 clk = ~clk;

  fp_addsub_sched #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .op1(op1), .op2(op2),
    .add_start(add_start), .add_serv(add_serv), .add_result(add_result), .add_done(add_done),
    .add_busy(add_busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy));

  // Adder stand-in: busy for 5 cycles after start, then done held until serviced.
  assign add_busy = m_busy;
  assign add_done = m_done;
  assign add_result = (op1 == 32'h3F80_0000 && op2 == 32'h4000_0000) ? 32'h4040_0000 :
                      (op1 == 32'h4040_0000 && op2 == 32'hBF80_0000) ? 32'h4000_0000 : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_cnt <= 0;
    end else if (add_start) begin
      m_busy <= 1; m_cnt <= 1;
    end else if (m_busy) begin
      if (m_cnt == 5) begin m_busy <= 0; m_done <= 1; end
      else m_cnt <= m_cnt + 1;
    end else if (m_done && add_serv) m_done <= 0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns 1ns after the accepting edge (start of cycle 1).
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [3:0] t);
    int n = 0;
    req_a = a; req_b = b; req_sub = sub; req_tag = t; req_valid = 1;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    cmp++;
    if (req_ready !== 1'b1) begin errs++; $display("FAIL send_ready: got %b required 1", req_ready); end
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic pop_one;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    cmp++;
    if ({req_ready, busy, rsp_valid, add_start, add_serv} !== 5'b0)
      begin errs++; $display("FAIL reset_ctrl: got %b required 00000", {req_ready, busy, rsp_valid, add_start, add_serv}); end
    cmp++;
    if ({op1, op2} !== 64'h0) begin errs++; $display("FAIL reset_ops: got %h required 0", {op1, op2}); end
    rst = 0;
    send(32'h3F80_0000, 32'h4000_0000, 0, 4'd9);
    repeat (3) @(negedge clk);
    cmp++;
    if ({busy, add_busy} !== 2'b11) begin errs++; $display("FAIL reset_midwait_busy: got %b required 11", {busy, add_busy}); end
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    cmp++;
    if ({req_ready, busy, rsp_valid, add_serv} !== 4'b0 || op1 !== 32'h0 || op2 !== 32'h0)
      begin errs++; $display("FAIL reset_midwait: got %b op1 %h op2 %h required 0", {req_ready, busy, rsp_valid, add_serv}, op1, op2); end
    rst = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      cmp++;
      if ({add_start, add_serv, rsp_valid, busy, req_ready} !== 5'b00001)
        begin errs++; $display("FAIL reset_after c%0d: got %b required 00001", c, {add_start, add_serv, rsp_valid, busy, req_ready}); end
    end
  endtask

  task automatic test_add;
    send(32'h3F80_0000, 32'h4000_0000, 0, 4'd3);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      cmp++;
      if ({add_start, add_serv, rsp_valid, busy} !== {c == 1, c == 8, c >= 8, c <= 8})
        begin errs++; $display("FAIL add_timing c%0d: got %b required %b", c, {add_start, add_serv, rsp_valid, busy}, {c == 1, c == 8, c >= 8, c <= 8}); end
      if (c == 8) begin
        cmp++;
        if ({rsp_result, rsp_tag, rsp_err} !== {32'h4040_0000, 4'd3, 1'b0})
          begin errs++; $display("FAIL add_rsp: got %h/%h/%b required 40400000/3/0", rsp_result, rsp_tag, rsp_err); end
      end
      if (c == 9) begin
        cmp++;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL add_ready_c9: got %b required 1", req_ready); end
      end
    end
    pop_one;
    cmp++;
    if ({rsp_valid, rsp_result, rsp_tag} !== 37'h0) begin errs++; $display("FAIL add_empty: got %b/%h/%h required 0", rsp_valid, rsp_result, rsp_tag); end
  endtask

  task automatic test_sub;
    send(32'h4040_0000, 32'h3F80_0000, 1, 4'd5);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      cmp++;
      if (op1 !== 32'h4040_0000 || op2 !== 32'hBF80_0000)
        begin errs++; $display("FAIL sub_ops c%0d: got %h %h required 40400000 bf800000", c, op1, op2); end
      if (c == 8) begin
        cmp++;
        if ({rsp_valid, rsp_result, rsp_tag} !== {1'b1, 32'h4000_0000, 4'd5})
          begin errs++; $display("FAIL sub_rsp: got %b/%h/%h required 1/40000000/5", rsp_valid, rsp_result, rsp_tag); end
      end
    end
    pop_one;
  endtask

  task automatic test_backpressure;
    rsp_ready = 0;
    for (int t = 0; t < 4; t++) send(32'h3F80_0000, 32'h4000_0000, 0, 4'(t));
    repeat (9) @(negedge clk);
    cmp++;
    if ({req_ready, rsp_valid, busy} !== 3'b010) begin errs++; $display("FAIL bp_full: got %b required 010", {req_ready, rsp_valid, busy}); end
    repeat (3) @(negedge clk);
    cmp++;
    if (req_ready !== 1'b0) begin errs++; $display("FAIL bp_full_hold: got %b required 0", req_ready); end
    cmp++;
    if (rsp_tag !== 4'd0) begin errs++; $display("FAIL bp_head0: got %h required 0", rsp_tag); end
    pop_one;
    cmp++;
    if (req_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_after_pop: got %b required 1", req_ready); end
    for (int t = 1; t < 4; t++) begin
      cmp++;
      if ({rsp_valid, rsp_tag, rsp_result} !== {1'b1, 4'(t), 32'h4040_0000})
        begin errs++; $display("FAIL bp_drain%0d: got %b/%h/%h required 1/%0d/40400000", t, rsp_valid, rsp_tag, rsp_result, t); end
      pop_one;
    end
    cmp++;
    if (rsp_valid !== 1'b0) begin errs++; $display("FAIL bp_empty: got %b required 0", rsp_valid); end
  endtask

  task automatic test_back_to_back;
    int nxt = 0;
    logic prev = 0;
    time ta [5];
    rsp_ready = 1;
    fork
      for (int t = 0; t < 5; t++) begin
        send(32'h3F80_0000, 32'h4000_0000, 0, 4'(8 + t));
        ta[t] = $time;
      end
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        cmp++;
        if (rsp_valid && prev) begin errs++; $display("FAIL b2b_count cyc%0d: got two-cycle head required single", i); end
        if (rsp_valid) begin
          cmp++;
          if (rsp_tag !== 4'(8 + nxt) || rsp_result !== 32'h4040_0000)
            begin errs++; $display("FAIL b2b_order: got %h/%h required %0d/40400000", rsp_tag, rsp_result, 8 + nxt); end
          nxt++;
        end
        prev = rsp_valid;
      end
    join
    for (int t = 1; t < 5; t++) begin
      cmp++;
      if (ta[t] - ta[t-1] !== 90) begin errs++; $display("FAIL b2b_interval%0d: got %0t required 90", t, ta[t] - ta[t-1]); end
    end
    cmp++;
    if (nxt !== 5) begin errs++; $display("FAIL b2b_total: got %0d required 5", nxt); end
    rsp_ready = 0;
  endtask

`ifdef FP_SCHED_SPECIAL_BYPASS_EN
  task automatic test_bypass;
    send(32'h7F80_0000, 32'h3F80_0000, 0, 4'd6);
    @(negedge clk);
    cmp++;
    if ({rsp_valid, add_start, busy} !== 3'b001) begin errs++; $display("FAIL byp_c1: got %b required 001", {rsp_valid, add_start, busy}); end
    @(negedge clk);
    cmp++;
    if ({rsp_valid, rsp_err, rsp_tag, rsp_result, add_start, req_ready} !== {1'b1, 1'b1, 4'd6, 32'h7FC0_0000, 1'b0, 1'b1})
      begin errs++; $display("FAIL byp_nan: got %b/%b/%h/%h required 1/1/6/7fc00000", rsp_valid, rsp_err, rsp_tag, rsp_result); end
    pop_one;
    send(32'h0000_0000, 32'h3F80_0000, 1, 4'd7);
    repeat (2) @(negedge clk);
    cmp++;
    if ({rsp_valid, rsp_err, rsp_tag, rsp_result} !== {1'b1, 1'b0, 4'd7, 32'hBF80_0000})
      begin errs++; $display("FAIL byp_zero: got %b/%b/%h/%h required 1/0/7/bf800000", rsp_valid, rsp_err, rsp_tag, rsp_result); end
    pop_one;
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_backpressure;
    test_back_to_back;
`ifdef FP_SCHED_SPECIAL_BYPASS_EN
    test_bypass;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
